// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_serializer
// Brief    : Serialises 24-bit stereo mixer samples onto an I2S link with an
//            internally divided BCLK/LRCK and a single-entry pending buffer.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_serializer #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SLOT_WIDTH    = 32,
    parameter int BCLK_DIV      = 2
) (
    input  logic                     sCLK_XVXENVS,
    input  logic                     reset_data_N,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    input  logic                     clr_status,
    output logic                     sample_req,
    output logic                     i2s_bclk,
    output logic                     i2s_lrck,
    output logic                     i2s_data,
    output logic                     underrun,
    output logic                     overrun
);

    localparam int c_DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int c_FRAME = 2 * SLOT_WIDTH;
    localparam int c_BIT_W = $clog2(c_FRAME);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME - 1);
    localparam logic [c_BIT_W-1:0] c_SLOT     = c_BIT_W'(SLOT_WIDTH);

    logic [c_DIV_W-1:0]       r_div_cnt;
    logic                     r_bclk;
    logic [c_BIT_W-1:0]       r_bit_cnt;
    logic                     r_lrck;
    logic                     r_data;
    logic                     r_underrun;
    logic                     r_overrun;
    logic                     r_pend_full;
    logic [AUD_BIT_DEPTH-1:0] r_pend_l;
    logic [AUD_BIT_DEPTH-1:0] r_pend_r;
    logic [AUD_BIT_DEPTH-1:0] r_act_l;
    logic [AUD_BIT_DEPTH-1:0] r_act_r;

    logic                     w_div_wrap;
    logic                     w_fall;
    logic                     w_load;
    logic [c_BIT_W-1:0]       w_bit_nxt;
    logic                     w_slot;
    logic [c_BIT_W-1:0]       w_pos;
    logic [AUD_BIT_DEPTH-1:0] w_act_l_nxt;
    logic [AUD_BIT_DEPTH-1:0] w_act_r_nxt;
    logic [AUD_BIT_DEPTH-1:0] w_sample;
    logic [SLOT_WIDTH-1:0]    w_word;
    logic [SLOT_WIDTH-1:0]    w_word_sh;

    assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
    assign w_fall     = r_bclk && w_div_wrap;
    assign w_bit_nxt  = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + c_BIT_W'(1);
    assign w_load     = w_fall && (w_bit_nxt == '0);

    // Bit 0 of a new frame must already see the freshly loaded sample.
    assign w_act_l_nxt = w_load ? (r_pend_full ? r_pend_l : '0) : r_act_l;
    assign w_act_r_nxt = w_load ? (r_pend_full ? r_pend_r : '0) : r_act_r;

    assign w_slot   = (w_bit_nxt >= c_SLOT);
    assign w_pos    = w_slot ? (w_bit_nxt - c_SLOT) : w_bit_nxt;
    assign w_sample = w_slot ? w_act_r_nxt : w_act_l_nxt;

    // Slot image: position p drives word[SLOT_WIDTH-1-p]; the leading zero
    // bit provides the one-BCLK delay between the LRCK edge and the MSB.
    always_comb begin
        w_word = '0;
        w_word[SLOT_WIDTH-2 -: AUD_BIT_DEPTH] = w_sample;
    end
    assign w_word_sh = w_word << w_pos;

    always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
        if (!reset_data_N) begin
            r_div_cnt   <= '0;
            r_bclk      <= 1'b0;
            r_bit_cnt   <= c_BIT_LAST;
            r_lrck      <= 1'b0;
            r_data      <= 1'b0;
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;
            r_pend_full <= 1'b0;
            r_pend_l    <= '0;
            r_pend_r    <= '0;
            r_act_l     <= '0;
            r_act_r     <= '0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + c_DIV_W'(1);
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= w_slot;
                r_data    <= w_word_sh[SLOT_WIDTH-1];
            end
            r_act_l <= w_act_l_nxt;
            r_act_r <= w_act_r_nxt;

            // A load in the same clock as a strobe consumes the old contents.
            if (sample_valid) begin
                r_pend_l    <= lsound_in;
                r_pend_r    <= rsound_in;
                r_pend_full <= 1'b1;
            end else if (w_load) begin
                r_pend_full <= 1'b0;
            end

            if (clr_status) begin
                r_underrun <= 1'b0;
                r_overrun  <= 1'b0;
            end
            if (w_load && !r_pend_full) begin
                r_underrun <= 1'b1;
            end
            if (sample_valid && r_pend_full && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign sample_req = w_load;
    assign i2s_bclk   = r_bclk;
    assign i2s_lrck   = r_lrck;
    assign i2s_data   = r_data;
    assign underrun   = r_underrun;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Consumes the parallel 24-bit stereo samples from the synth engine's mixer output (lsound_out/rsound_out) and serialises them onto a standard I2S link for the codec DAC.
- Generates the link signals i2s_bclk and i2s_lrck internally by dividing the system clock.
- Holds one pending stereo sample, which is loaded into the shifter at each frame boundary.
- Reports underrun and overrun through sticky status flags.

Parameters:
AUD_BIT_DEPTH, 24, sample width per channel; must be <= SLOT_WIDTH-1.
SLOT_WIDTH, 32, BCLK periods per channel slot.
BCLK_DIV, 2, system clocks per BCLK half-period; must be >= 1.

Ports:
sCLK_XVXENVS  in  1  system clock; all logic on its rising edge.
reset_data_N  in  1  asynchronous, active-low reset.
lsound_in  in  AUD_BIT_DEPTH  left sample, two's complement.
rsound_in  in  AUD_BIT_DEPTH  right sample, two's complement.
sample_valid  in  1  one-clock strobe; captures lsound_in/rsound_in into the pending buffer.
clr_status  in  1  clears underrun and overrun.
sample_req  out  1  one-clock pulse at frame load; requests the next sample.
i2s_bclk  out  1  bit clock.
i2s_lrck  out  1  word select; 0 = left, 1 = right.
i2s_data  out  1  serial data, MSB first.
underrun  out  1  sticky: a frame loaded with the pending buffer empty.
overrun  out  1  sticky: sample_valid arrived while the pending buffer was full.

Behaviour:
- Reset values (asynchronous): i2s_bclk=0, i2s_lrck=0, i2s_data=0, sample_req=0, underrun=0, overrun=0, div_cnt=0, bit_cnt=2*SLOT_WIDTH-1, pending empty, active L/R registers=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1.
  - On the clock where div_cnt==BCLK_DIV-1, div_cnt wraps to 0 and i2s_bclk toggles.
  - BCLK period = 2*BCLK_DIV clocks.
- Falling-edge events: on the clock where i2s_bclk toggles 1->0, do all of the following:
  - bit_cnt <= (bit_cnt+1) mod 2*SLOT_WIDTH.
  - i2s_lrck and i2s_data are registered in the same clock from the new bit_cnt.
  - Outputs change only on BCLK falling edges, so the receiver samples them on rising edges.
- Slot mapping:
  - slot = bit_cnt / SLOT_WIDTH; p = bit_cnt mod SLOT_WIDTH.
  - i2s_lrck = slot.
  - i2s_data = sample[AUD_BIT_DEPTH-p] for 1 <= p <= AUD_BIT_DEPTH, otherwise 0.
  - sample is the active L register for slot 0 and the active R register for slot 1.
  - This gives the standard I2S one-BCLK delay between an LRCK edge and the MSB.
- Frame load: on the falling-edge event where the new bit_cnt is 0:
  - If the pending buffer is full: active L/R <= pending contents; pending becomes empty.
  - If the pending buffer is empty: active L/R <= 0 (mute); underrun <= 1.
  - sample_req pulses high for exactly that clock in both cases.
  - Bit 0 uses the newly loaded active registers.
- Pending buffer:
  - sample_valid with the buffer empty: capture both channels; buffer becomes full.
  - sample_valid with the buffer full and no load in that clock: overwrite with the new data; overrun <= 1.
- Simultaneous frame load and sample_valid in the same clock:
  - The load uses the pending contents from before the write. If the buffer was empty, the frame is muted and underrun is set.
  - The new sample is captured; the buffer ends full.
  - overrun is not set.
  - There is no bypass from lsound_in/rsound_in straight to the active registers.
- Status flags:
  - clr_status clears underrun and overrun.
  - If clr_status coincides with a set condition, the set wins.
- Timing:
  - Frame period = 2*SLOT_WIDTH*2*BCLK_DIV clocks (256 with the defaults).
  - The first falling edge after reset deassertion occurs 2*BCLK_DIV clocks later (clock 4 with the defaults) and performs a frame load.
- Reset mid-frame: everything returns to reset values immediately; any pending sample is discarded; framing restarts as after power-up.

Test Plan:
1. After reset, strobe sample_valid with L=24'hA5A5A5, R=24'h123456 before the first load -> frame 1 has lrck low for 32 BCLKs then high for 32; data bits p=1..24 of the left slot = A5A5A5 MSB-first, p=25..31 and p=0 = 0; right slot = 123456; one sample_req pulse; no flags set.
2. No sample_valid after the first frame -> frame 2 outputs all-zero data; underrun=1 after the load; clr_status returns it to 0; a new strobe then plays normally in the next frame.
3. Two strobes within one frame (L=24'h000001, then L=24'h800000) -> overrun=1; the next frame's left slot is 800000 (MSB at p=1, all other bits 0).
4. sample_valid asserted exactly on the sample_req clock, with the buffer empty -> that frame is muted and underrun=1; the strobed value plays in the following frame; overrun stays 0.
5. BCLK_DIV=1 and BCLK_DIV=3 -> BCLK period is 2 and 6 clocks; frame period is 128 and 384 clocks; lrck and data transitions are aligned only to BCLK falling edges.
6. Assert reset_data_N mid-right-slot with the buffer full -> all outputs are 0 immediately; after release, the first frame is muted and sets underrun (the pending sample was discarded).
